// File: rtl/lcd_capture.sv
// Rebuilds the serial LCD pixel stream into a double-buffered frame buffer, four 2-bit
// pixels per byte, first pixel in the top bits.
module lcd_capture #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pixel_data,
  input  logic        pixel_clock,
  input  logic        pixel_latch,
  input  logic        hsync,
  input  logic        vsync,
  output logic        fb_we,
  output logic [13:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        display_bank,
  output logic        frame_done,
  output logic [2:0]  err_flags,
  input  logic        err_clr
);

  localparam logic [7:0] LineWidth = 8'd160;
  localparam logic [7:0] NumLines  = 8'd144;

  if (SYNC_STAGES < 2) begin : gen_bad_param
    $error("SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {StSync, StActive, StVblank} state_e;

  // Bundle layout: {pixel_data[1:0], pixel_clock, pixel_latch, hsync, vsync}
  logic [5:0] raw;
  logic [5:0] sync_q [SYNC_STAGES];
  logic [5:0] sig;
  logic [2:0] prev_q;   // {pixel_clock, pixel_latch, vsync}

  assign raw = {pixel_data, pixel_clock, pixel_latch, hsync, vsync};
  assign sig = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= {sig[3], sig[2], sig[0]};
    end
  end

  logic [1:0] pdat;
  logic       hs;
  logic       pclk_rise;
  logic       latch_rise;
  logic       vs_rise;
  logic       vs_fall;

  assign pdat       = sig[5:4];
  assign hs         = sig[1];
  assign pclk_rise  = sig[3] & ~prev_q[2];
  assign latch_rise = sig[2] & ~prev_q[1];
  assign vs_rise    = sig[0] & ~prev_q[0];
  assign vs_fall    = ~sig[0] & prev_q[0];

  state_e     state_q;
  logic [7:0] x_q;
  logic [7:0] y_q;
  logic [7:0] pack_q;
  logic       wr_bank_q;

  logic        active;
  logic        pix_ev;
  logic        pix_ok;
  logic        pix_wr;
  logic        err_long;
  logic [7:0]  x_p;
  logic [7:0]  pack_p;
  logic        lat_ev;
  logic        lat_wr;
  logic        err_short;
  logic [7:0]  y_l;
  logic        frame_ev;
  logic        full_frame;
  logic        wr_any;
  logic [12:0] line_base;
  logic [12:0] wr_idx;
  logic [7:0]  wr_data;
  logic [2:0]  err_set;

  // Pixel is applied first, then latch, then vsync rise, all within one cycle.
  always_comb begin
    active    = (state_q == StActive);
    pix_ev    = active & pclk_rise & ~hs;
    pix_ok    = pix_ev & (y_q < NumLines) & (x_q < LineWidth);
    err_long  = pix_ev & (y_q < NumLines) & (x_q == LineWidth);
    x_p       = pix_ok ? x_q + 8'd1 : x_q;
    pack_p    = pix_ok ? {pack_q[5:0], pdat} : pack_q;
    pix_wr    = pix_ok & (x_q[1:0] == 2'd3);

    lat_ev    = active & latch_rise;
    lat_wr    = lat_ev & (x_p[1:0] != 2'd0);
    err_short = lat_ev & (x_p < LineWidth);
    y_l       = (lat_ev && (y_q < NumLines)) ? y_q + 8'd1 : y_q;

    frame_ev   = active & vs_rise;
    full_frame = (y_l == NumLines);

    // A completing pixel leaves x%4==0, so pixel and latch never both write.
    wr_any    = pix_wr | lat_wr;
    line_base = ({5'd0, y_q} << 5) + ({5'd0, y_q} << 3);
    wr_idx    = line_base + {7'd0, x_q[7:2]};

    wr_data = pack_p;
    if (!pix_wr) begin
      unique case (x_p[1:0])
        2'd1:    wr_data = {pack_p[1:0], 6'd0};
        2'd2:    wr_data = {pack_p[3:0], 4'd0};
        2'd3:    wr_data = {pack_p[5:0], 2'd0};
        default: wr_data = pack_p;
      endcase
    end

    err_set = {frame_ev & ~full_frame, err_long, err_short};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StSync;
      x_q        <= '0;
      y_q        <= '0;
      pack_q     <= '0;
      wr_bank_q  <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      frame_done <= 1'b0;
      err_flags  <= '0;
    end else begin
      fb_we      <= wr_any;
      frame_done <= frame_ev;
      err_flags  <= (err_flags & ~{3{err_clr}}) | err_set;
      if (wr_any) begin
        fb_addr <= {wr_bank_q, wr_idx};
        fb_data <= wr_data;
      end

      unique case (state_q)
        StSync, StVblank: begin
          if (vs_fall) begin
            state_q <= StActive;
            x_q     <= '0;
            y_q     <= '0;
            pack_q  <= '0;
          end
        end
        StActive: begin
          x_q    <= lat_ev ? 8'd0 : x_p;
          pack_q <= lat_ev ? 8'd0 : pack_p;
          y_q    <= y_l;
          if (frame_ev) begin
            state_q <= StVblank;
            if (full_frame) wr_bank_q <= ~wr_bank_q;
          end
        end
        default: state_q <= StSync;
      endcase
    end
  end

  assign display_bank = ~wr_bank_q;

endmodule

// File: tb/tb_lcd_capture.sv
// Directed, table-driven bench for lcd_capture: line packing, error flags, bank flipping
// and reset behaviour.
module tb_lcd_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  pixel_data;
  logic        pixel_clock;
  logic        pixel_latch;
  logic        hsync;
  logic        vsync;
  logic        fb_we;
  logic [13:0] fb_addr;
  logic [7:0]  fb_data;
  logic        display_bank;
  logic        frame_done;
  logic [2:0]  err_flags;
  logic        err_clr;

  lcd_capture #(.SYNC_STAGES(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .pixel_data   (pixel_data),
    .pixel_clock  (pixel_clock),
    .pixel_latch  (pixel_latch),
    .hsync        (hsync),
    .vsync        (vsync),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .display_bank (display_bank),
    .frame_done   (frame_done),
    .err_flags    (err_flags),
    .err_clr      (err_clr)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  logic [13:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];

  always @(negedge clock) begin
    if (!reset) begin
      if (fb_we) begin
        wr_addr_q.push_back(fb_addr);
        wr_data_q.push_back(fb_data);
      end
      if (frame_done) fd_cnt++;
    end
  end

  typedef struct {
    int         npix;
    logic [1:0] val;
    int         exp_wr;
    logic [7:0] exp_last;
    logic [2:0] exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pix(input logic [1:0] v);
    pixel_data  = v;
    pixel_clock = 1'b1;
    wait_clks(3);
    pixel_clock = 1'b0;
    wait_clks(3);
  endtask

  task automatic latch();
    pixel_latch = 1'b1;
    wait_clks(3);
    pixel_latch = 1'b0;
    wait_clks(3);
  endtask

  task automatic vs(input logic v);
    vsync = v;
    wait_clks(6);
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    wait_clks(1);
    err_clr = 1'b0;
    wait_clks(1);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    fd_cnt = 0;
  endtask

  // Line 0 carries 160 pixels, lines 1..143 carry four pixels each (0,1,2,3).
  task automatic send_frame();
    vs(1'b0);
    for (int x = 0; x < 160; x++) pix(2'(x % 4));
    latch();
    for (int y = 1; y < 144; y++) begin
      for (int x = 0; x < 4; x++) pix(2'(x));
      latch();
    end
    clr_err();
    vs(1'b1);
  endtask

  task automatic check_frame(input string name, input int base);
    int bad;
    int exp_a;
    bad = 0;
    chk({name, "_count"}, wr_addr_q.size(), 183);
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      exp_a = (i < 40) ? base + i : base + (i - 39) * 40;
      if (int'(wr_addr_q[i]) != exp_a || wr_data_q[i] != 8'h1B) bad++;
    end
    chk({name, "_content_bad"}, bad, 0);
    chk({name, "_frame_done"}, fd_cnt, 1);
    chk({name, "_err"}, err_flags, 0);
  endtask

  initial begin
    vecs[0] = '{npix: 6,   val: 2'd3, exp_wr: 2,  exp_last: 8'hF0, exp_err: 3'b001};
    vecs[1] = '{npix: 1,   val: 2'd2, exp_wr: 1,  exp_last: 8'h80, exp_err: 3'b001};
    vecs[2] = '{npix: 4,   val: 2'd1, exp_wr: 1,  exp_last: 8'h55, exp_err: 3'b001};
    vecs[3] = '{npix: 7,   val: 2'd2, exp_wr: 2,  exp_last: 8'hA8, exp_err: 3'b001};
    vecs[4] = '{npix: 164, val: 2'd1, exp_wr: 40, exp_last: 8'h55, exp_err: 3'b010};
    vecs[5] = '{npix: 160, val: 2'd0, exp_wr: 40, exp_last: 8'h00, exp_err: 3'b000};

    reset = 1'b1;
    pixel_data = 2'd0;
    pixel_clock = 1'b0;
    pixel_latch = 1'b0;
    hsync = 1'b0;
    vsync = 1'b1;
    err_clr = 1'b0;
    wait_clks(3);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_display_bank", display_bank, 1);
    reset = 1'b0;
    wait_clks(4);

    // Strobes before any vsync fall are ignored.
    clear_log();
    for (int i = 0; i < 5; i++) pix(2'd3);
    latch();
    chk("sync_ignored_writes", wr_addr_q.size(), 0);
    chk("sync_ignored_err", err_flags, 0);

    vs(1'b0);
    hsync = 1'b1;
    for (int i = 0; i < 4; i++) pix(2'd2);
    hsync = 1'b0;
    wait_clks(2);
    chk("hblank_ignored_writes", wr_addr_q.size(), 0);

    for (int i = 0; i < 6; i++) begin
      clear_log();
      for (int p = 0; p < vecs[i].npix; p++) pix(vecs[i].val);
      latch();
      chk($sformatf("vec%0d_nwr", i), wr_addr_q.size(), vecs[i].exp_wr);
      if (wr_addr_q.size() > 0) begin
        chk($sformatf("vec%0d_first_addr", i), wr_addr_q[0], i * 40);
        chk($sformatf("vec%0d_last_data", i), wr_data_q[wr_data_q.size()-1], vecs[i].exp_last);
      end else begin
        chk($sformatf("vec%0d_no_write", i), 0, 1);
      end
      chk($sformatf("vec%0d_err", i), err_flags, vecs[i].exp_err);
      clr_err();
      chk($sformatf("vec%0d_err_clr", i), err_flags, 0);
    end

    // Short frame: six lines received.
    clear_log();
    vs(1'b1);
    chk("short_frame_done", fd_cnt, 1);
    chk("short_frame_err", err_flags, 3'b100);
    chk("short_frame_bank", display_bank, 1);
    chk("short_frame_nwr", wr_addr_q.size(), 0);
    clr_err();

    clear_log();
    send_frame();
    check_frame("frameA", 0);
    chk("frameA_bank", display_bank, 0);

    clear_log();
    send_frame();
    check_frame("frameB", 14'h2000);
    chk("frameB_bank", display_bank, 1);

    // Reset in the middle of a line.
    vs(1'b0);
    for (int x = 0; x < 50; x++) pix(2'(x % 4));
    reset = 1'b1;
    #1;
    chk("midrst_fb_we", fb_we, 0);
    chk("midrst_fb_addr", fb_addr, 0);
    chk("midrst_fb_data", fb_data, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_err", err_flags, 0);
    chk("midrst_bank", display_bank, 1);
    wait_clks(2);
    reset = 1'b0;
    wait_clks(2);
    clear_log();
    for (int i = 0; i < 4; i++) pix(2'd1);
    latch();
    chk("midrst_ignored_writes", wr_addr_q.size(), 0);
    vs(1'b1);
    vs(1'b0);
    pix(2'd3);
    pix(2'd2);
    pix(2'd1);
    pix(2'd0);
    chk("restart_nwr", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      chk("restart_addr", wr_addr_q[0], 0);
      chk("restart_data", wr_data_q[0], 8'hE4);
    end
    chk("restart_frame_done", fd_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_capture.md
# lcd_capture

Receives the serial pixel stream the gameboy core drives on its Video Display pins (pixel_data, pixel_clock, pixel_latch, hsync, vsync) and rebuilds the frame in an external double-buffered frame-buffer RAM, packing four 2-bit pixels per byte. It is the display-side end of the core's video output. A downstream scan-out block (VGA doubler or LCD driver) reads the completed bank while the next frame is written.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on all five video inputs (minimum 2).

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- pixel_data  in  2  pixel shade; sampled on a pixel_clock rising edge.
- pixel_clock  in  1  pixel strobe, asynchronous to clock.
- pixel_latch  in  1  rising edge marks end of line.
- hsync  in  1  high = horizontal blank; pixel strobes are ignored.
- vsync  in  1  high = vertical blank; falling edge starts a frame.
- fb_we  out  1  one-cycle frame-buffer write strobe.
- fb_addr  out  14  {wr_bank, byte index 0..5759}.
- fb_data  out  8  packed pixels; first pixel in [7:6], fourth in [1:0].
- display_bank  out  1  bank holding the last complete frame (= ~wr_bank).
- frame_done  out  1  one-cycle pulse at every frame end.
- err_flags  out  3  sticky: [0] short line, [1] long line, [2] short frame.
- err_clr  in  1  clears err_flags.

## Operation
- Inputs pass through SYNC_STAGES flops. Rise and fall events come from the synchronized value and its registered copy.
- Geometry is fixed: 160 pixels by 144 lines, 40 bytes per line. Byte index = y*40 + x/4.
- FSM states:
  - SYNC: the state after reset. Ignores everything except a vsync fall.
  - ACTIVE: receiving a frame.
  - VBLANK: between frames.
- FSM transitions:
  - vsync fall in SYNC or VBLANK: go to ACTIVE and set x=0, y=0.
  - vsync rise in ACTIVE: go to VBLANK.
- Pixel handling in ACTIVE, on a pixel_clock rise with hsync low:
  - If x<160 and y<144, shift the pixel into the pack register and increment x.
  - On the 4th pixel of a group, write the byte.
  - If x=160, drop the pixel and set err[1].
  - If y>=144, drop the pixel silently.
- Line end (pixel_latch rise in ACTIVE):
  - If x%4≠0, write the partial byte with the unused low pixels zero.
  - If x<160, set err[0].
  - Set x=0 and clear the pack register. If y<144, y increments.
- Frame end (vsync rise in ACTIVE):
  - frame_done pulses.
  - If y=144, toggle wr_bank.
  - Otherwise set err[2] and leave wr_bank unchanged.
- Simultaneous events in one cycle are processed in this order: pixel, then latch, then vsync rise.
- err_clr clears all flags. If a new error occurs in the same cycle as err_clr, the set wins.
- Pixel or latch events in SYNC or VBLANK are ignored and set no flags.

## Timing
- Reset (asynchronous) values:
  - fb_we=0, fb_addr=0, fb_data=0, frame_done=0, err_flags=0.
  - wr_bank=0 (so display_bank=1), state=SYNC, x=y=0.
- Reset mid-line or mid-frame abandons the frame. No write or frame_done follows until a new vsync fall.
- Latency from a raw input edge to the detected event is SYNC_STAGES+1 clocks.
- fb_we, fb_addr and fb_data are registered together. They are valid in the cycle after the event that completes the byte.
- At most one write per event; writes are never back-to-back closer than one pixel period.
- frame_done asserts the cycle after the vsync rise is detected.
- display_bank updates in the same cycle as frame_done.
- Input constraint: pixel_clock high and low must each last ≥ SYNC_STAGES+1 clocks. Faster input is undefined; nothing is guaranteed.

## Test plan
- Full frame after reset, vsync falling, 144 lines of 160 pixels with value = x%4 → 5760 writes of 0x1B to addresses 0..5759. Then vsync rises → one frame_done, display_bank 1→0, err_flags=0.
- Second full frame → addresses 0x2000..0x367F, display_bank returns to 1.
- Short line: 6 pixels of 3 then latch at y=0 → 0xFF @0, 0xF0 @1, err[0]=1. The next line's first write goes to @40.
- Long line: 164 pixels then latch → exactly 40 writes for that line, err[1]=1. Then err_clr → err_flags=0.
- Short frame: vsync rises after 100 lines → frame_done pulses, err[2]=1, display_bank unchanged. The next frame rewrites from the same bank base.
- Ignored input: pixel strobes before the first vsync fall, and with hsync high → no fb_we.
- Reset mid-line: assert reset at x=50 → all outputs zero immediately. Strobes are ignored until vsync falls, and the frame restarts at byte 0.
